// File: rtl/logits_stream_tx.sv
// Logits transmitter: gathers per-class accumulators in any order, requantizes to Q15/25-bit,
// then streams them in ascending class order. Optional argmax output under LOGITS_TX_ARGMAX_EN.
module logits_stream_tx #(
  parameter int CLASS_NUM = 10,
  parameter int IDX_W     = 4,
  parameter int ACC_W     = 32,
  parameter int ACC_FRAC  = 22
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             acc_valid,
  output logic             acc_ready,
  input  logic [IDX_W-1:0] acc_idx,
  input  logic [ACC_W-1:0] acc_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [24:0]      out_data,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             done,
  output logic             idx_err,
  output logic             dbg_state
`ifdef LOGITS_TX_ARGMAX_EN
  ,
  output logic [IDX_W-1:0] pred_class,
  output logic             pred_valid
`endif
);

  // Handshakes: a word moves on a clock edge where valid and ready are both high;
  // out_valid/out_data never depend combinationally on out_ready.
  typedef enum logic {FILL = 1'b0, SEND = 1'b1} state_t;

  localparam int SH     = ACC_FRAC - 15;
  localparam int RND_SH = (SH > 0) ? SH - 1 : 0;
  localparam logic signed [ACC_W:0] RND  = (SH > 0) ? ((ACC_W+1)'(1) << RND_SH) : '0;
  localparam logic signed [ACC_W:0] QMAX = (ACC_W+1)'(24'hFFFFFF);
  localparam logic signed [ACC_W:0] QMIN = ~QMAX;
  localparam logic [IDX_W:0]   N_EXT = (IDX_W+1)'(CLASS_NUM);
  localparam logic [IDX_W-1:0] LAST  = IDX_W'(CLASS_NUM - 1);

  state_t                 state_q, state_d;
  logic [CLASS_NUM-1:0]   mask_q, mask_d;
  logic [IDX_W-1:0]       ptr_q, ptr_d;
  logic                   acc_ready_q, acc_ready_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
  logic [24:0]            buf_q [CLASS_NUM];
  logic                   wr_en, idx_ok, out_hs;
  logic signed [ACC_W:0]  ext_s, sh_s;
  logic [24:0]            q_val;

  // Round half up, then clamp into the signed 25-bit range.
  always_comb begin
    ext_s = $signed({acc_data[ACC_W-1], acc_data}) + RND;
    sh_s  = ext_s >>> SH;
    if (sh_s > QMAX)      q_val = QMAX[24:0];
    else if (sh_s < QMIN) q_val = QMIN[24:0];
    else                  q_val = sh_s[24:0];
  end

  assign idx_ok = {1'b0, acc_idx} < N_EXT;
  assign out_hs = (state_q == SEND) && out_ready;

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    ptr_d   = ptr_q;
    done_d  = 1'b0;
    err_d   = err_q;
    wr_en   = 1'b0;
    case (state_q)
      FILL: begin
        if (acc_valid && acc_ready_q) begin
          if (idx_ok) begin
            wr_en  = 1'b1;
            mask_d = mask_q | (CLASS_NUM'(1) << acc_idx);
            if (&mask_d) begin
              state_d = SEND;
              ptr_d   = '0;
            end
          end else begin
            err_d = 1'b1;
          end
        end
      end
      SEND: begin
        if (out_hs) begin
          if (ptr_q == LAST) begin
            state_d = FILL;
            mask_d  = '0;
            ptr_d   = '0;
            done_d  = 1'b1;
          end else begin
            ptr_d = ptr_q + 1'b1;
          end
        end
      end
      default: state_d = FILL;
    endcase
    acc_ready_d = (state_d == FILL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= FILL;
      mask_q      <= '0;
      ptr_q       <= '0;
      acc_ready_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      for (int i = 0; i < CLASS_NUM; i++) buf_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      ptr_q       <= ptr_d;
      acc_ready_q <= acc_ready_d;
      done_q      <= done_d;
      err_q       <= err_d;
      if (wr_en) buf_q[acc_idx] <= q_val;
    end
  end

  assign acc_ready = acc_ready_q;
  assign out_valid = (state_q == SEND);
  assign out_data  = out_valid ? buf_q[ptr_q] : '0;
  assign out_idx   = out_valid ? ptr_q : '0;
  assign out_last  = out_valid && (ptr_q == LAST);
  assign done      = done_q;
  assign idx_err   = err_q;
  assign dbg_state = state_q;

`ifdef LOGITS_TX_ARGMAX_EN
  logic signed [24:0] max_q, max_d;
  logic [IDX_W-1:0]   arg_q, arg_d, pred_q, pred_d;
  logic               pv_q, pv_d, take;

  // Strict greater-than keeps the lowest index on ties; ptr 0 seeds the running max.
  always_comb begin
    max_d = max_q;
    arg_d = arg_q;
    pred_d = pred_q;
    pv_d  = 1'b0;
    take  = (ptr_q == '0) || ($signed(out_data) > max_q);
    if (out_hs) begin
      if (take) begin
        max_d = $signed(out_data);
        arg_d = ptr_q;
      end
      if (ptr_q == LAST) begin
        pred_d = take ? ptr_q : arg_q;
        pv_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      max_q  <= '0;
      arg_q  <= '0;
      pred_q <= '0;
      pv_q   <= 1'b0;
    end else begin
      max_q  <= max_d;
      arg_q  <= arg_d;
      pred_q <= pred_d;
      pv_q   <= pv_d;
    end
  end

  assign pred_class = pred_q;
  assign pred_valid = pv_q;
`endif

endmodule

// File: tb/tb_logits_stream_tx.sv
// Scoreboard bench for logits_stream_tx: writers push expected words, a negedge monitor checks them.
module tb_logits_stream_tx;
  localparam int N  = 10;
  localparam int IW = 4;
  localparam int AW = 32;
  localparam int DW = 25;
  localparam int EW = 1 + IW + DW;

  logic          clk;
  logic          rst;
  logic          acc_valid;
  logic          acc_ready;
  logic [IW-1:0] acc_idx;
  logic [AW-1:0] acc_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [IW-1:0] out_idx;
  logic          out_last;
  logic          done;
  logic          idx_err;
  logic          dbg_state;
`ifdef LOGITS_TX_ARGMAX_EN
  logic [IW-1:0] pred_class;
  logic          pred_valid;
`endif

  logits_stream_tx #(.CLASS_NUM(N), .IDX_W(IW), .ACC_W(AW), .ACC_FRAC(22)) dut (
    .clk(clk), .rst(rst), .acc_valid(acc_valid), .acc_ready(acc_ready),
    .acc_idx(acc_idx), .acc_data(acc_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_idx(out_idx), .out_last(out_last), .done(done),
    .idx_err(idx_err), .dbg_state(dbg_state)
`ifdef LOGITS_TX_ARGMAX_EN
    , .pred_class(pred_class), .pred_valid(pred_valid)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int hs_cnt = 0;
  int done_cnt = 0;
  logic [EW-1:0] exp_q[$];
  logic [DW-1:0] mdl_buf [N];
  logic [N-1:0]  mdl_mask = '0;
  logic [IW-1:0] exp_pred = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic push_all();
    exp_pred = '0;
    for (int i = 0; i < N; i++) begin
      exp_q.push_back({(i == N-1), IW'(i), mdl_buf[i]});
      if (i > 0 && $signed(mdl_buf[i]) > $signed(mdl_buf[exp_pred])) exp_pred = IW'(i);
    end
    mdl_mask = '0;
  endtask

  // driver: call at posedge+#1; returns at posedge+#1 after the word is taken
  task automatic write_acc(input logic [IW-1:0] idx, input logic [AW-1:0] data,
                           input logic [DW-1:0] expv);
    int n;
    n = 0;
    acc_valid = 1'b1;
    acc_idx   = idx;
    acc_data  = data;
    while (!acc_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!acc_ready) begin
      total++; bad++;
      $display("FAIL acc_ready_timeout: got 0 expected 1 (idx %0d)", idx);
      acc_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    acc_valid = 1'b0;
    if (idx < N) begin
      mdl_buf[idx]  = expv;
      mdl_mask[idx] = 1'b1;
      if (&mdl_mask) push_all();
    end
  endtask

  task automatic drain(input int mode);
    int hs0, d0, hold;
    hs0 = hs_cnt; d0 = done_cnt; hold = 0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (done_cnt != d0) break;
      if (mode == 0) out_ready = 1'b1;
      else if (out_valid && out_idx == 4 && hold < 5) begin
        out_ready = 1'b0;
        hold++;
      end else out_ready = ~out_ready;
      @(posedge clk); #1;
    end
    check("drain_done", done_cnt - d0, 1);
    check("hs_count", hs_cnt - hs0, N);
    check("exp_q_empty", exp_q.size(), 0);
    out_ready = 1'b1;
  endtask

  task automatic fill_linear(input int scale, input int expscale);
    for (int k = 0; k < N; k++)
      write_acc(IW'(k), AW'(scale * k), DW'(expscale * k));
  endtask

  // monitor / scoreboard
  logic          prev_last_hs = 1'b0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic [IW-1:0] prev_idx;
  logic [EW-1:0] mon_e;

  always @(negedge clk) begin
    if (rst) begin
      prev_last_hs = 1'b0;
      prev_stall   = 1'b0;
    end else begin
      if (done || prev_last_hs) begin
        check("done_pulse", done, prev_last_hs);
        if (done) done_cnt++;
`ifdef LOGITS_TX_ARGMAX_EN
        if (prev_last_hs) begin
          check("pred_valid", pred_valid, 1);
          check("pred_class", pred_class, exp_pred);
        end
`endif
      end
      if (prev_stall && out_valid) begin
        check("stall_data", out_data, prev_data);
        check("stall_idx", out_idx, prev_idx);
      end
      if (out_valid) check("acc_ready_in_send", acc_ready, 0);
      prev_last_hs = 1'b0;
      prev_stall   = out_valid && !out_ready;
      prev_data    = out_data;
      prev_idx     = out_idx;
      if (out_valid && out_ready) begin
        hs_cnt++;
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL extra_word: got idx %0d expected none", out_idx);
        end else begin
          mon_e = exp_q.pop_front();
          check("out_last", out_last, mon_e[EW-1]);
          check("out_idx", out_idx, mon_e[EW-2:DW]);
          check("out_data", out_data, mon_e[DW-1:0]);
        end
        prev_last_hs = out_last;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs0;
    rst = 1'b0; acc_valid = 1'b0; acc_idx = '0; acc_data = '0; out_ready = 1'b1;
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_acc_ready", acc_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_idx", out_idx, 0);
    check("rst_out_last", out_last, 0);
    check("rst_done", done, 0);
    check("rst_idx_err", idx_err, 0);
    rst = 1'b0;
    check("ready_before_edge", acc_ready, 0);
    @(posedge clk); #1;
    check("ready_after_edge", acc_ready, 1);

    // linear fill 128*k -> k, latency check on first valid
    for (int k = 0; k < N-1; k++) write_acc(IW'(k), AW'(128 * k), DW'(k));
    check("pre_valid", out_valid, 0);
    write_acc(4'd9, 32'd1152, 25'd9);
    check("first_valid", out_valid, 1);
    check("first_idx", out_idx, 0);
    drain(0);

    // rounding and saturation
    out_ready = 1'b0;
    write_acc(4'd0, 32'd192, 25'd2);
    write_acc(4'd1, -32'sd192, -25'sd1);
    write_acc(4'd2, 32'd63, 25'd0);
    write_acc(4'd3, 32'd64, 25'd1);
    write_acc(4'd4, -32'sd65, -25'sd1);
    write_acc(4'd5, 32'h7FFF_FFFF, 25'd16777215);
    write_acc(4'd6, 32'h8000_0000, 25'h100_0000);
    write_acc(4'd7, 32'd0, 25'd0);
    write_acc(4'd8, 32'd0, 25'd0);
    write_acc(4'd9, 32'd0, 25'd0);
    drain(0);

    // out-of-order, overwrite, bad index
    out_ready = 1'b0;
    write_acc(4'd9, 32'd1152, 25'd9);
    write_acc(4'd3, 32'd128, 25'd1);
    write_acc(4'd0, 32'd0, 25'd0);
    write_acc(4'd12, 32'd5000, 25'd0);
    write_acc(4'd3, 32'd640, 25'd5);
    write_acc(4'd1, 32'd128, 25'd1);
    write_acc(4'd2, 32'd256, 25'd2);
    for (int k = 4; k < 9; k++) write_acc(IW'(k), AW'(128 * k), DW'(k));
    check("idx_err_set", idx_err, 1);
    drain(0);

    // back-pressure with toggling ready and a 5-cycle hold at idx 4
    out_ready = 1'b0;
    fill_linear(384, 3);
    drain(1);

    // reset mid-stream
    out_ready = 1'b0;
    fill_linear(128, 1);
    out_ready = 1'b1;
    hs0 = hs_cnt;
    for (int c = 0; c < 50 && (hs_cnt - hs0) < 6; c++) @(negedge clk);
    check("six_sent", hs_cnt - hs0, 6);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_out_data", out_data, 0);
    check("arst_out_idx", out_idx, 0);
    check("arst_out_last", out_last, 0);
    check("arst_acc_ready", acc_ready, 0);
    check("arst_done", done, 0);
    check("arst_idx_err", idx_err, 0);
    exp_q.delete();
    mdl_mask = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    check("ready_after_arst", acc_ready, 1);

    // refill with a tie for the maximum at idx 2 and 7
    out_ready = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (k == 2 || k == 7) write_acc(IW'(k), 32'd6400, 25'd50);
      else write_acc(IW'(k), AW'(128 * k), DW'(k));
    end
`ifdef LOGITS_TX_ARGMAX_EN
    check("tie_pred_model", exp_pred, 2);
`endif
    drain(0);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/logits_stream_tx.md
Name: logits_stream_tx

Overview:
- Transmit end of the logits interface consumed by the softmax/classification stage.
- Collects the final dense-layer accumulators, one per class, in any order, and requantizes each to signed 25-bit Q15 with rounding and saturation.
- Once all classes are present, streams them out in class order 0..CLASS_NUM-1 over a valid/ready handshake, flagging the last one.
- Sits between the final FC accumulator bank and the softmax stage.

Parameters:
- CLASS_NUM, 10, number of logits per inference.
- IDX_W, 4, class index width; must satisfy 2^IDX_W >= CLASS_NUM.
- ACC_W, 32, signed accumulator input width.
- ACC_FRAC, 22, fractional bits of the accumulator input; must be >= 15.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- acc_valid  in  1  accumulator word present.
- acc_ready  out  1  block accepts accumulator words.
- acc_idx  in  IDX_W  class index of acc_data.
- acc_data  in  ACC_W  signed accumulator, Q(ACC_W-ACC_FRAC).ACC_FRAC.
- out_valid  out  1  logit word present.
- out_ready  in  1  downstream accepts the logit.
- out_data  out  25  signed Q15 logit.
- out_idx  out  IDX_W  class index of out_data.
- out_last  out  1  high with index CLASS_NUM-1.
- done  out  1  one-cycle pulse after the last output handshake.
- idx_err  out  1  sticky: an out-of-range acc_idx was accepted.

Behaviour:
- Reset values: acc_ready=0, out_valid=0, out_data=0, out_idx=0, out_last=0, done=0, idx_err=0. Presence mask, buffer and pointer cleared; state=FILL.
- Reset asserted mid-stream aborts everything; there is no partial resume.
- State FILL:
  - acc_ready=1 from the first clock edge after reset release.
  - Handshake = acc_valid & acc_ready.
  - Each handshake with acc_idx < CLASS_NUM writes buf[acc_idx] and sets mask[acc_idx].
  - A repeated index overwrites the stored value (last write wins).
  - acc_idx >= CLASS_NUM is accepted and discarded, and sets idx_err. idx_err clears only on rst.
- FILL -> SEND:
  - Taken on the edge where the mask becomes all-ones.
  - acc_ready drops and out_valid rises in the cycle after the completing write (latency 1).
  - ptr=0.
- State SEND:
  - out_valid=1, out_data=buf[ptr], out_idx=ptr, out_last=(ptr==CLASS_NUM-1). acc_ready=0.
  - Outputs hold stable while out_ready=0; there is no combinational ready->valid path.
  - Handshake with ptr<CLASS_NUM-1: ptr increments, next word presented the next cycle. Sustained throughput is 1 word/cycle.
  - Handshake with ptr==CLASS_NUM-1: next cycle out_valid=0, out_last=0, done=1 for exactly one cycle, mask cleared, ptr=0, state=FILL, acc_ready=1.
  - acc_valid during SEND is ignored and not consumed.
- Requantization, applied at write time:
  - SH = ACC_FRAC-15.
  - Computed in ACC_W+1 bits: t = acc_data + (SH>0 ? 2^(SH-1) : 0), then arithmetic shift right by SH. This is round-half-up (toward +inf).
  - Saturate t to [-16777216, 16777215] before storing in 25 bits.
- Buffer: CLASS_NUM x 25-bit registers.
- Order of output is always ascending index, regardless of write order.

Optional Feature:
- Macro: LOGITS_TX_ARGMAX_EN.
- When defined, adds ports:
  - pred_class  out  IDX_W
  - pred_valid  out  1
- During SEND, a running max is updated on each output handshake using strict greater-than, so ties keep the lowest index.
- pred_valid pulses with done, and pred_class holds the argmax until the next done. Both reset to 0.
- When undefined, those ports and the compare logic do not exist; all other behaviour is identical.

Test Plan:
- Write idx 0..9 with acc_data=128*k (SH=7), out_ready=1 -> out_data=0..9 on consecutive cycles, out_valid first seen 1 cycle after the idx-9 write, out_last with idx 9, done 1 cycle later.
- Rounding: acc_data=192 -> 2; -192 -> -1; 63 -> 0; 64 -> 1; -65 -> -1.
- Saturation: acc_data=2147483647 -> 16777215; acc_data=-2147483648 -> -16777216.
- Write order 9,3,0,..., with idx 3 written twice (values 128 then 640), plus idx=12 -> stream in order 0..9, idx 3 out_data=5, idx_err=1, no extra word.
- out_ready toggling 1/0 and held 0 for 5 cycles at idx 4 -> data/idx stable while stalled, exactly 10 handshakes, acc_ready=0 throughout SEND.
- rst pulse after 6 words sent -> all outputs 0 asynchronously. A subsequent full fill streams correctly. With LOGITS_TX_ARGMAX_EN and equal max at idx 2 and 7 -> pred_class=2.
